// File: rtl/regfile_wport_arbiter.sv
// Regfile write-port arbiter: WB has priority, MDU results queue in a small FIFO and drain on idle WB cycles.
// Optional same-cycle MDU bypass when the FIFO is empty: define RF_ARB_BYPASS_EN.
module regfile_wport_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        wb_we,
  input  logic [4:0]  wb_wn,
  input  logic [31:0] wb_d,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_wn,
  input  logic [31:0] md_d,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic        pend_a,
  output logic        pend_b,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_d
);

  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       wn_q [DEPTH];
  logic [31:0]      d_q  [DEPTH];

  logic wb_act, fifo_empty, push, pop, byp;

  // Handshake and arbitration decisions
  always_comb begin
    wb_act     = wb_we & (wb_wn != 5'd0);
    fifo_empty = (count_q == '0);
    md_ready   = (count_q != CW'(DEPTH));
    pop        = ~wb_act & ~fifo_empty;
`ifdef RF_ARB_BYPASS_EN
    byp        = ~wb_act & fifo_empty & md_valid;
`else
    byp        = 1'b0;
`endif
    push       = md_valid & md_ready & ~byp;
  end

  // Write-port mux; a dead head still pops but with the enable low
  always_comb begin
    rf_we = 1'b0;
    rf_wn = 5'd0;
    rf_d  = 32'd0;
    if (wb_act) begin
      rf_we = 1'b1;
      rf_wn = wb_wn;
      rf_d  = wb_d;
    end else if (pop) begin
      rf_we = live_q[rd_ptr_q];
      rf_wn = wn_q[rd_ptr_q];
      rf_d  = d_q[rd_ptr_q];
    end else if (byp && (md_wn != 5'd0)) begin
      rf_we = 1'b1;
      rf_wn = md_wn;
      rf_d  = md_d;
    end
  end

  // Queue bookkeeping; WB kills older same-register entries, a same-cycle push stays live
  always_comb begin
    live_d   = live_q;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (pop) live_d[rd_ptr_q] = 1'b0;
    if (wb_act) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wn_q[i] == wb_wn) live_d[i] = 1'b0;
      end
    end
    if (push) live_d[wr_ptr_q] = (md_wn != 5'd0);
  end

  // Hazard flags from registered queue state only
  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (wn_q[i] == rna)) pend_a = 1'b1;
      if (live_q[i] && (wn_q[i] == rnb)) pend_b = 1'b1;
    end
    pend_a = pend_a & (rna != 5'd0);
    pend_b = pend_b & (rnb != 5'd0);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
    end
  end

  // Payload storage needs no reset; validity is carried by live_q and count_q
  always_ff @(posedge clk) begin
    if (push) begin
      wn_q[wr_ptr_q] <= md_wn;
      d_q[wr_ptr_q]  <= md_d;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: queue-based reference model as scoreboard,
// plus per-scenario directed checks. Honours RF_ARB_BYPASS_EN when defined.
module tb_regfile_wport_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic        wb_we;
  logic [4:0]  wb_wn;
  logic [31:0] wb_d;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_wn;
  logic [31:0] md_d;
  logic [4:0]  rna, rnb;
  logic        pend_a, pend_b;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;

  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] d;
    logic        live;
  } ent_t;

  ent_t        mdq[$];
  logic [31:0] shadow [32];
  logic        r0_written;
  int          n_checks;
  int          n_fail;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .clrn(clrn),
    .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
    .md_valid(md_valid), .md_ready(md_ready), .md_wn(md_wn), .md_d(md_d),
    .rna(rna), .rnb(rnb), .pend_a(pend_a), .pend_b(pend_b),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d)
  );

  // One clock: compare outputs at negedge against the model, then advance the model at posedge
  task automatic cycle();
    logic        exp_we, exp_ready, exp_pa, exp_pb, act, byp, pop, push;
    logic [4:0]  exp_wn;
    logic [31:0] exp_d;
    ent_t        e;
    @(negedge clk);
    act       = wb_we && (wb_wn != 5'd0);
    exp_ready = (mdq.size() != DEPTH);
    byp       = 1'b0;
`ifdef RF_ARB_BYPASS_EN
    byp       = !act && (mdq.size() == 0) && md_valid;
`endif
    exp_we = 1'b0; exp_wn = 5'd0; exp_d = 32'd0;
    if (act) begin
      exp_we = 1'b1; exp_wn = wb_wn; exp_d = wb_d;
    end else if (mdq.size() > 0) begin
      exp_we = mdq[0].live; exp_wn = mdq[0].wn; exp_d = mdq[0].d;
    end else if (byp && (md_wn != 5'd0)) begin
      exp_we = 1'b1; exp_wn = md_wn; exp_d = md_d;
    end
    exp_pa = 1'b0; exp_pb = 1'b0;
    foreach (mdq[k]) begin
      if (mdq[k].live && (mdq[k].wn == rna) && (rna != 5'd0)) exp_pa = 1'b1;
      if (mdq[k].live && (mdq[k].wn == rnb) && (rnb != 5'd0)) exp_pb = 1'b1;
    end
    n_checks++;
    if ({rf_we, rf_wn, rf_d} !== {exp_we, exp_wn, exp_d}) begin
      n_fail++;
      $display("FAIL wport @%0t: rf_we/wn/d=%b/%0d/%h expected %b/%0d/%h", $time,
               rf_we, rf_wn, rf_d, exp_we, exp_wn, exp_d);
    end
    n_checks++;
    if (md_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL md_ready @%0t: got %b expected %b", $time, md_ready, exp_ready);
    end
    n_checks++;
    if ({pend_a, pend_b} !== {exp_pa, exp_pb}) begin
      n_fail++;
      $display("FAIL pend @%0t: pend_a/b=%b/%b expected %b/%b", $time, pend_a, pend_b, exp_pa, exp_pb);
    end
    if (rf_we === 1'b1) begin
      shadow[rf_wn] = rf_d;
      if (rf_wn == 5'd0) r0_written = 1'b1;
    end
    pop  = !act && (mdq.size() > 0);
    push = md_valid && exp_ready && !byp;
    @(posedge clk);
    if (pop) mdq.delete(0);
    if (act) foreach (mdq[k]) if (mdq[k].wn == wb_wn) mdq[k].live = 1'b0;
    if (push) begin
      e.wn = md_wn; e.d = md_d; e.live = (md_wn != 5'd0);
      mdq.push_back(e);
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_wn = 5'd0; wb_d = 32'd0;
    md_valid = 1'b0; md_wn = 5'd0; md_d = 32'd0;
    rna = 5'd0; rnb = 5'd0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    idle_inputs();
    #12;
    n_checks++;
    if ({rf_we, md_ready, pend_a, pend_b} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_init: we/ready/pa/pb=%b%b%b%b expected 0100", rf_we, md_ready, pend_a, pend_b);
    end
    @(negedge clk); clrn = 1'b1;
    @(posedge clk); #1;
    // Hold the FIFO with WB traffic while 3 entries queue up
    wb_we = 1'b1; wb_wn = 5'd1; rna = 5'd2; rnb = 5'd3;
    md_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      md_wn = 5'(2 + i); md_d = 32'h100 + 32'(i); wb_d = 32'(i);
      cycle();
    end
    md_valid = 1'b0;
    cycle();
    wb_we = 1'b0;
    #1 clrn = 1'b0;
    #1;
    n_checks++;
    if ({rf_we, md_ready, pend_a, pend_b} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_mid: we/ready/pa/pb=%b%b%b%b expected 0100", rf_we, md_ready, pend_a, pend_b);
    end
    mdq.delete();
    @(negedge clk); clrn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle();
    idle_inputs();
  endtask

  task automatic test_drain();
    rna = 5'd5; rnb = 5'd6;
    md_valid = 1'b1;
    md_wn = 5'd5; md_d = 32'h11; cycle();
    md_wn = 5'd6; md_d = 32'h22; cycle();
    md_wn = 5'd7; md_d = 32'h33; cycle();
    md_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if ({shadow[5], shadow[6], shadow[7]} !== {32'h11, 32'h22, 32'h33}) begin
      n_fail++;
      $display("FAIL drain_data: r5/r6/r7=%h/%h/%h expected 11/22/33", shadow[5], shadow[6], shadow[7]);
    end
    idle_inputs();
  endtask

  task automatic test_priority_full();
    wb_we = 1'b1; md_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wb_wn = 5'(20 + i); wb_d = 32'hC000 + 32'(i);
      md_wn = 5'(8 + i);  md_d = 32'hD000 + 32'(i);
      cycle();
    end
    n_checks++;
    if (md_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: md_ready=%b expected 0", md_ready);
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) cycle();
    n_checks++;
    if ({shadow[11], shadow[12], md_ready} !== {32'hD003, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL full_drain: r11=%h r12=%h ready=%b expected d003/0/1", shadow[11], shadow[12], md_ready);
    end
  endtask

  task automatic test_waw_kill();
    wb_we = 1'b1; wb_wn = 5'd1; wb_d = 32'h1;
    rna = 5'd9;
    md_valid = 1'b1; md_wn = 5'd9; md_d = 32'hAAAA;
    cycle();
    md_valid = 1'b0;
    wb_wn = 5'd9; wb_d = 32'hBBBB;
    cycle();
    n_checks++;
    if (pend_a !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_pend: pend_a=%b expected 0", pend_a);
    end
    wb_we = 1'b0; wb_wn = 5'd0;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (shadow[9] !== 32'hBBBB) begin
      n_fail++;
      $display("FAIL waw_data: r9=%h expected 0000bbbb", shadow[9]);
    end
    idle_inputs();
  endtask

  task automatic test_pending();
    wb_we = 1'b1; wb_wn = 5'd1; wb_d = 32'h2;
    rna = 5'd3; rnb = 5'd0;
    md_valid = 1'b1; md_wn = 5'd3; md_d = 32'h3333;
    cycle();
    md_valid = 1'b0;
    n_checks++;
    if ({pend_a, pend_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL pend_set: pend_a/b=%b/%b expected 1/0", pend_a, pend_b);
    end
    wb_we = 1'b0; wb_wn = 5'd0;
    cycle();
    n_checks++;
    if (pend_a !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_clear: pend_a=%b expected 0", pend_a);
    end
    cycle();
    idle_inputs();
  endtask

  task automatic test_r0_wrap();
    logic [31:0] vals [2*DEPTH];
    r0_written = 1'b0;
    md_valid = 1'b1; md_wn = 5'd0; md_d = 32'hDEAD;
    cycle();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      vals[i] = $urandom;
      md_wn = 5'(16 + i); md_d = vals[i];
      rna = 5'(16 + i); rnb = (i > 0) ? 5'(15 + i) : 5'd0;
      cycle();
    end
    md_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      n_checks++;
      if (shadow[16 + i] !== vals[i]) begin
        n_fail++;
        $display("FAIL wrap_data r%0d: got %h expected %h", 16 + i, shadow[16 + i], vals[i]);
      end
    end
    n_checks++;
    if ({r0_written, md_ready, rf_we} !== 3'b010) begin
      n_fail++;
      $display("FAIL wrap_end: r0_written/ready/we=%b%b%b expected 010", r0_written, md_ready, rf_we);
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    r0_written = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    test_reset();
    test_drain();
    test_priority_full();
    test_waw_kill();
    test_pending();
    test_r0_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
